ifq_multi_fetch: RTL and testbench

- Parametrised successor to the single-issue instruction fetch queue, sitting between the instruction cache and dispatch.
- Fetches FETCH_W instructions per cache access, drops the leading instructions of a misaligned line after a redirect, and tags every entry with its PC.
- Provides first-word-fall-through reads to dispatch, a redirect/flush with cache abort, and occupancy status.

---
 rtl/ifq_pkg.sv | 20 ++
 rtl/ifq_multi_fetch_storage.sv | 31 +++
 rtl/ifq_multi_fetch.sv | 145 ++++++++++++++
 tb/tb_ifq_multi_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and default sizing for the multi-fetch instruction queue.
// The module parameters default to the values below.
package ifq_pkg;

    localparam int IFQ_DEPTH   = 16;
    localparam int IFQ_FETCH_W = 4;
    localparam int IFQ_INST_W  = 32;
    localparam int IFQ_PC_W    = 32;

    localparam int OFS_W = $clog2(IFQ_FETCH_W);
    localparam int PTR_W = $clog2(IFQ_DEPTH);

    typedef enum logic {IDLE, WAIT} fetch_state_t;

    typedef struct packed {
        logic [IFQ_PC_W-1:0]   pc;
        logic [IFQ_INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_multi_fetch_storage.sv
// Entry array: FETCH_W-wide masked write starting at a base index (wrapping),
// plus one asynchronous read port for the queue head.
module ifq_storage #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 4,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   wr_base,
    input  logic [FETCH_W-1:0]         wr_mask,
    input  logic [FETCH_W*ENTRY_W-1:0] wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [ENTRY_W-1:0]         rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Lane j lands at wr_base + j; the AW-bit add wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        for (int j = 0; j < FETCH_W; j++) begin
            if (wr_mask[j]) begin
                mem[wr_base + AW'(j)] <= wr_data[j*ENTRY_W +: ENTRY_W];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ifq_multi_fetch.sv
// Instruction fetch queue: line-wide cache fetch, misaligned-head drop after a
// redirect, PC-tagged entries, FWFT head, flush with cache abort.
module ifq_multi_fetch
    import ifq_pkg::*;
#(
    parameter int              DEPTH    = IFQ_DEPTH,
    parameter int              FETCH_W  = IFQ_FETCH_W,
    parameter int              INST_W   = IFQ_INST_W,
    parameter int              PC_W     = IFQ_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [PC_W-1:0]           pc_in,
    output logic                      cache_rd_en,
    output logic                      cache_abort,
    input  logic [FETCH_W*INST_W-1:0] dout,
    input  logic                      dout_valid,
    output logic [PC_W-1:0]           pc_out,
    output logic [INST_W-1:0]         inst,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    input  logic                      inst_rd_en,
    input  logic [PC_W-1:0]           jmp_branch_address,
    input  logic                      jmp_branch_valid,
    output fetch_state_t              dbg_state
);

    localparam int OB = $clog2(FETCH_W);
    localparam int PB = $clog2(DEPTH);
    localparam int CB = PB + 1;
    localparam int EW = PC_W + INST_W;
    localparam logic [CB-1:0]   SPACE_LIMIT = CB'(DEPTH - FETCH_W);
    localparam logic [PC_W-1:0] LINE_MASK   = ~PC_W'(FETCH_W*4 - 1);
    localparam logic [PC_W-1:0] LINE_BYTES  = PC_W'(FETCH_W*4);

    fetch_state_t              state;
    logic [PC_W-1:0]           fetch_pc;
    logic [PB-1:0]             rd_ptr;
    logic [PB-1:0]             wr_ptr;
    logic [OB-1:0]             ofs;
    logic [CB-1:0]             n_words;
    logic [CB-1:0]             count_nxt;
    logic                      wr_fire;
    logic                      pop;
    logic [FETCH_W*INST_W-1:0] line_shifted;
    logic [FETCH_W-1:0]        wr_mask;
    logic [FETCH_W*EW-1:0]     wr_data;
    logic [EW-1:0]             rd_data;

    assign ofs     = fetch_pc[OB+1:2];
    assign pc_in   = fetch_pc & LINE_MASK;
    assign n_words = CB'(FETCH_W) - CB'(ofs);

    // A redirect in the same cycle discards the returning line.
    assign wr_fire = (state == WAIT) && dout_valid && !jmp_branch_valid && !rst;
    assign pop     = inst_rd_en && !empty;

    // Slide the line down so that slot OFS becomes write lane 0.
    assign line_shifted = dout >> (32'(ofs) * INST_W);

    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        for (int j = 0; j < FETCH_W; j++) begin
            wr_mask[j] = wr_fire && (CB'(j) < n_words);
            wr_data[j*EW +: EW] = {pc_in + PC_W'(4 * (32'(ofs) + j)),
                                   line_shifted[j*INST_W +: INST_W]};
        end
    end

    assign count_nxt = count + (wr_fire ? n_words : '0) - CB'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            cache_rd_en <= 1'b0;
            cache_abort <= 1'b0;
        end else if (jmp_branch_valid) begin
            state       <= IDLE;
            fetch_pc    <= jmp_branch_address;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            cache_rd_en <= 1'b0;
            cache_abort <= (state == WAIT);
        end else begin
            cache_abort <= 1'b0;
            if (pop) begin
                rd_ptr <= rd_ptr + PB'(1);
            end
            if (wr_fire) begin
                wr_ptr <= wr_ptr + n_words[PB-1:0];
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CB'(DEPTH));
            case (state)
                IDLE: begin
                    // Space is reserved against the registered count only; the
                    // abort cycle never launches a request.
                    if (!cache_abort && count <= SPACE_LIMIT) begin
                        state       <= WAIT;
                        cache_rd_en <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dout_valid) begin
                        state       <= IDLE;
                        cache_rd_en <= 1'b0;
                        fetch_pc    <= pc_in + LINE_BYTES;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifq_storage #(
        .DEPTH  (DEPTH),
        .FETCH_W(FETCH_W),
        .ENTRY_W(EW)
    ) u_storage (
        .clk    (clk),
        .wr_base(wr_ptr),
        .wr_mask(wr_mask),
        .wr_data(wr_data),
        .rd_idx (rd_ptr),
        .rd_data(rd_data)
    );

    assign pc_out    = rd_data[EW-1:INST_W];
    assign inst      = rd_data[INST_W-1:0];
    assign dbg_state = state;

endmodule

// File: tb/tb_ifq_multi_fetch.sv
// Bench for ifq_multi_fetch: cache model returning word = address after two
// cycles, and a scoreboard of expected {pc, inst} entries in dispatch order.
module tb_ifq_multi_fetch;
    import ifq_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pc_in;
    logic         cache_rd_en;
    logic         cache_abort;
    logic [127:0] dout = '0;
    logic         dout_valid = 1'b0;
    logic [31:0]  pc_out;
    logic [31:0]  inst;
    logic         empty;
    logic         full;
    logic [4:0]   count;
    logic         inst_rd_en = 1'b0;
    logic [31:0]  jmp_branch_address = '0;
    logic         jmp_branch_valid = 1'b0;
    fetch_state_t dbg_state;

    always #5 clk = ~clk;

    ifq_multi_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .pc_in             (pc_in),
        .cache_rd_en       (cache_rd_en),
        .cache_abort       (cache_abort),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .pc_out            (pc_out),
        .inst              (inst),
        .empty             (empty),
        .full              (full),
        .count             (count),
        .inst_rd_en        (inst_rd_en),
        .jmp_branch_address(jmp_branch_address),
        .jmp_branch_valid  (jmp_branch_valid),
        .dbg_state         (dbg_state)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc = '0;
    int          lat_cnt = 0;
    bit          cache_stall = 0;
    bit          stale = 0;
    logic [31:0] last_req_pc = '1;
    bit          want_first = 0;
    logic [31:0] first_pc = '0;
    int          pop_cnt = 0;
    bit          found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cache model: evaluated on the falling edge; a stale beat follows an abort.
    always @(negedge clk) begin
        dout_valid = 1'b0;
        stale      = 1'b0;
        if (cache_abort) begin
            dout_valid = 1'b1;
            dout       = '1;
            stale      = 1'b1;
            lat_cnt    = 0;
        end else if (!cache_rd_en || rst) begin
            lat_cnt = 0;
        end else if (!cache_stall) begin
            lat_cnt++;
            if (lat_cnt == 2) begin
                lat_cnt = 0;
                for (int k = 0; k < 4; k++) dout[k*32 +: 32] = pc_in + 32'(4*k);
                dout_valid  = 1'b1;
                last_req_pc = pc_in;
                chk("pc_in", pc_in, exp_fetch_pc & ~32'hF);
            end
        end
    end

    // Scoreboard update at the clock edge, from bench-driven signals only.
    always @(posedge clk) begin
        logic [31:0] base;
        if (rst) begin
            exp_q.delete();
            exp_fetch_pc = 32'h0;
        end else if (jmp_branch_valid) begin
            exp_q.delete();
            exp_fetch_pc = jmp_branch_address;
        end else if (dout_valid && !stale) begin
            base = exp_fetch_pc & ~32'hF;
            for (int j = int'(exp_fetch_pc[3:2]); j < 4; j++)
                exp_q.push_back({base + 32'(4*j), base + 32'(4*j)});
            exp_fetch_pc = base + 32'h10;
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("empty", 64'(empty), 64'(exp_q.size() == 0));
        chk("full", 64'(full), 64'(exp_q.size() == 16));
        chk("count_le_depth", 64'(count <= 5'd16), 64'd1);
    endtask

    task automatic drive(input bit do_pop, input bit do_jmp, input logic [31:0] addr);
        logic [63:0] tmp;
        if (do_pop && exp_q.size() > 0) begin
            chk("head", {pc_out, inst}, exp_q[0]);
            if (want_first) begin
                first_pc   = pc_out;
                want_first = 0;
            end
            tmp = exp_q.pop_front();
            pop_cnt++;
        end
        inst_rd_en         = do_pop;
        jmp_branch_valid   = do_jmp;
        jmp_branch_address = addr;
    endtask

    task automatic steps(input int n, input bit do_pop);
        for (int i = 0; i < n; i++) begin
            sample();
            drive(do_pop, 1'b0, 32'h0);
        end
    endtask

    task automatic pop_until_first(input string tag, input logic [31:0] exp_pc);
        want_first = 1;
        for (int i = 0; i < 30 && want_first; i++) begin
            sample();
            drive(1'b1, 1'b0, 32'h0);
        end
        if (want_first) chk({tag, "_timeout"}, 64'd0, 64'd1);
        else chk(tag, 64'(first_pc), 64'(exp_pc));
        want_first = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) sample();
        chk("rst_rd_en", 64'(cache_rd_en), 64'd0);
        chk("rst_abort", 64'(cache_abort), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        rst = 1'b0;

        // 1. Fill without popping, then drain with the cache stalled
        steps(25, 1'b0);
        chk("s1_full", 64'(full), 64'd1);
        chk("s1_count", 64'(count), 64'd16);
        chk("s1_rd_en", 64'(cache_rd_en), 64'd0);
        cache_stall = 1;
        steps(16, 1'b1);
        sample();
        chk("s1_empty", 64'(empty), 64'd1);
        drive(1'b0, 1'b0, 32'h0);
        cache_stall = 0;

        // 2. Continuous pop across pointer wrap
        pop_cnt = 0;
        steps(80, 1'b1);
        chk("s2_pops_ge_40", 64'(pop_cnt >= 40), 64'd1);

        // 3. Misaligned redirect from IDLE
        steps(30, 1'b0);
        sample();
        chk("s3_idle", 64'(dbg_state), 64'(IDLE));
        drive(1'b0, 1'b1, 32'h48);
        sample();
        chk("s3_no_abort", 64'(cache_abort), 64'd0);
        drive(1'b0, 1'b0, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (exp_q.size() > 0) found = 1;
            else drive(1'b0, 1'b0, 32'h0);
        end
        chk("s3_found", 64'(found), 64'd1);
        chk("s3_count", 64'(count), 64'd2);
        chk("s3_head_pc", 64'(pc_out), 64'h48);
        drive(1'b0, 1'b0, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (cache_rd_en) found = 1;
            drive(1'b0, 1'b0, 32'h0);
        end
        chk("s3_next_pc_in", 64'(pc_in), 64'h50);

        // 4. Branch during WAIT, one cycle before the line returns
        steps(30, 1'b0);
        drive(1'b0, 1'b1, 32'h20);
        sample();
        chk("s4_idle_branch_no_abort", 64'(cache_abort), 64'd0);
        drive(1'b0, 1'b0, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (cache_rd_en && lat_cnt == 1) begin
                found = 1;
                chk("s4_pc_in", 64'(pc_in), 64'h20);
                drive(1'b0, 1'b1, 32'h100);
            end else begin
                drive(1'b0, 1'b0, 32'h0);
            end
        end
        chk("s4_found", 64'(found), 64'd1);
        sample();
        chk("s4_abort", 64'(cache_abort), 64'd1);
        chk("s4_rd_en", 64'(cache_rd_en), 64'd0);
        chk("s4_count", 64'(count), 64'd0);
        drive(1'b0, 1'b0, 32'h0);
        sample();
        chk("s4_abort_once", 64'(cache_abort), 64'd0);
        drive(1'b0, 1'b0, 32'h0);
        pop_until_first("s4_first_pc", 32'h100);

        // 5. Branch coincident with dout_valid and pop, then pop on empty
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            sample();
            if (dout_valid && !stale && exp_q.size() > 0) begin
                found = 1;
                drive(1'b1, 1'b1, 32'h200);
            end else begin
                drive(1'b0, 1'b0, 32'h0);
            end
        end
        chk("s5_found", 64'(found), 64'd1);
        sample();
        chk("s5_count", 64'(count), 64'd0);
        chk("s5_abort", 64'(cache_abort), 64'd1);
        drive(1'b1, 1'b0, 32'h0);
        sample();
        chk("s5_pop_empty_count", 64'(count), 64'd0);
        chk("s5_pop_empty_empty", 64'(empty), 64'd1);
        drive(1'b0, 1'b0, 32'h0);
        pop_until_first("s5_first_pc", 32'h200);

        // 6. Reset while a request is outstanding
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (cache_rd_en) begin
                found = 1;
                rst = 1'b1;
                drive(1'b0, 1'b0, 32'h0);
            end else begin
                drive(1'b1, 1'b0, 32'h0);
            end
        end
        chk("s6_found", 64'(found), 64'd1);
        sample();
        chk("s6_rd_en", 64'(cache_rd_en), 64'd0);
        chk("s6_abort", 64'(cache_abort), 64'd0);
        chk("s6_count", 64'(count), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (exp_q.size() > 0) found = 1;
            drive(1'b0, 1'b0, 32'h0);
        end
        chk("s6_found_data", 64'(found), 64'd1);
        chk("s6_first_req_pc", 64'(last_req_pc), 64'h0);
        chk("s6_head_pc", 64'(pc_out), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
